// File: rtl/obi_axi_lite_pkg.sv
// Shared types and constants for the OBI to AXI4-Lite bridge.
package obi_axi_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    // Kind of transaction waiting for its response, kept in issue order.
    typedef enum logic {
        TXN_WRITE = 1'b0,
        TXN_READ  = 1'b1
    } txn_type_e;

    // Width of a counter that must hold 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // SLVERR and DECERR both surface as an OBI error; OKAY/EXOKAY do not.
    function automatic logic resp_is_error(input logic [1:0] resp);
        logic err;
        unique case (resp)
            RESP_OKAY, RESP_EXOKAY:   err = 1'b0;
            RESP_SLVERR, RESP_DECERR: err = 1'b1;
            default:                  err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/obi_axi_lite_order_fifo.sv
// Circular FIFO of transaction types, one entry per accepted-but-unresponded
// request. Callers never push when full nor pop when empty.
module obi_axi_lite_order_fifo
    import obi_axi_lite_pkg::*;
#(
    parameter int unsigned Depth = 2,
    localparam int unsigned CntWidth = count_width(Depth)
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                push,
    input  txn_type_e           push_type,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output txn_type_e           head,
    output logic [CntWidth-1:0] count
);

    localparam int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1;

    typedef logic [PtrWidth-1:0] ptr_t;

    localparam ptr_t LastPtr = ptr_t'(Depth - 1);

    txn_type_e           mem [Depth];
    ptr_t                wr_ptr;
    ptr_t                rd_ptr;
    logic [CntWidth-1:0] cnt_q;

    function automatic ptr_t ptr_next(input ptr_t p);
        return (p == LastPtr) ? '0 : ptr_t'(p + 1'b1);
    endfunction

    // Storage needs no reset: the explicit count guards every read of head.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= push_type;
        end
    end

    // Wrap-around pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= ptr_next(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_next(rd_ptr);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + 1'b1;
            end else if (pop && !push) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign full  = (cnt_q == CntWidth'(Depth));
    assign empty = (cnt_q == '0);
    assign head  = mem[rd_ptr];
    assign count = cnt_q;

endmodule

// File: rtl/obi_to_axi_lite_bridge.sv
// OBI slave to AXI4-Lite master bridge with in-order responses.
//
// Issue stage states:
//   state        | meaning
//   -------------+-------------------------------------------------------
//   ISSUE_IDLE   | stage empty, a new OBI request may be granted
//   ISSUE_WRITE  | AW and/or W still waiting for their handshakes
//   ISSUE_READ   | AR waiting for its handshake
module obi_to_axi_lite_bridge
    import obi_axi_lite_pkg::*;
#(
    parameter int unsigned AddrWidth      = 32,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned MaxOutstanding = 2,
    parameter logic [2:0]  AxiProt        = 3'b000,
    localparam int unsigned StrbWidth     = DataWidth / 8,
    localparam int unsigned CntWidth      = count_width(MaxOutstanding)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic                 obi_req_i,
    output logic                 obi_gnt_o,
    input  logic [AddrWidth-1:0] obi_addr_i,
    input  logic                 obi_we_i,
    input  logic [StrbWidth-1:0] obi_be_i,
    input  logic [DataWidth-1:0] obi_wdata_i,
    output logic                 obi_rvalid_o,
    output logic [DataWidth-1:0] obi_rdata_o,
    output logic                 obi_err_o,

    output logic [AddrWidth-1:0] aw_addr_o,
    output logic [2:0]           aw_prot_o,
    output logic                 aw_valid_o,
    input  logic                 aw_ready_i,

    output logic [DataWidth-1:0] w_data_o,
    output logic [StrbWidth-1:0] w_strb_o,
    output logic                 w_valid_o,
    input  logic                 w_ready_i,

    input  logic [1:0]           b_resp_i,
    input  logic                 b_valid_i,
    output logic                 b_ready_o,

    output logic [AddrWidth-1:0] ar_addr_o,
    output logic [2:0]           ar_prot_o,
    output logic                 ar_valid_o,
    input  logic                 ar_ready_i,

    input  logic [DataWidth-1:0] r_data_i,
    input  logic [1:0]           r_resp_i,
    input  logic                 r_valid_i,
    output logic                 r_ready_o,

    output logic                 busy_o,
    output logic [CntWidth-1:0]  outstanding_o
);

    typedef enum logic [1:0] {
        ISSUE_IDLE  = 2'd0,
        ISSUE_WRITE = 2'd1,
        ISSUE_READ  = 2'd2
    } issue_state_e;

    issue_state_e        state_q;
    logic                issue_idle;
    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;
    logic                b_hs;
    logic                r_hs;
    logic                aw_done;
    logic                w_done;
    logic                fifo_full;
    logic                fifo_empty;
    txn_type_e           fifo_head;
    logic [CntWidth-1:0] fifo_count;

    assign issue_idle = (state_q == ISSUE_IDLE);

    // Grant depends only on local state so OBI never waits on AXI readiness.
    assign obi_gnt_o = obi_req_i & issue_idle & ~fifo_full;

    assign aw_hs = aw_valid_o & aw_ready_i;
    assign w_hs  = w_valid_o & w_ready_i;
    assign ar_hs = ar_valid_o & ar_ready_i;

    // A write channel counts as done if it handshakes now or already has.
    assign aw_done = aw_hs | ~aw_valid_o;
    assign w_done  = w_hs | ~w_valid_o;

    // Only the response type at the head of the order FIFO is accepted, and
    // never while the single-entry response register is presenting.
    assign b_ready_o = ~fifo_empty & (fifo_head == TXN_WRITE) & ~obi_rvalid_o;
    assign r_ready_o = ~fifo_empty & (fifo_head == TXN_READ) & ~obi_rvalid_o;
    assign b_hs      = b_valid_i & b_ready_o;
    assign r_hs      = r_valid_i & r_ready_o;

    assign aw_prot_o     = AxiProt;
    assign ar_prot_o     = AxiProt;
    assign busy_o        = (fifo_count != '0) | ~issue_idle;
    assign outstanding_o = fifo_count;

    obi_axi_lite_order_fifo #(
        .Depth (MaxOutstanding)
    ) i_order_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (obi_gnt_o),
        .push_type (obi_we_i ? TXN_WRITE : TXN_READ),
        .pop       (b_hs | r_hs),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    // Issue stage: latch the granted request and hold the AXI payload stable
    // until each channel has handshaken.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ISSUE_IDLE;
            aw_valid_o <= 1'b0;
            w_valid_o  <= 1'b0;
            ar_valid_o <= 1'b0;
            aw_addr_o  <= '0;
            w_data_o   <= '0;
            w_strb_o   <= '0;
            ar_addr_o  <= '0;
        end else begin
            unique case (state_q)
                ISSUE_IDLE: begin
                    if (obi_gnt_o) begin
                        if (obi_we_i) begin
                            state_q    <= ISSUE_WRITE;
                            aw_valid_o <= 1'b1;
                            w_valid_o  <= 1'b1;
                            aw_addr_o  <= obi_addr_i;
                            w_data_o   <= obi_wdata_i;
                            w_strb_o   <= obi_be_i;
                        end else begin
                            state_q    <= ISSUE_READ;
                            ar_valid_o <= 1'b1;
                            ar_addr_o  <= obi_addr_i;
                        end
                    end
                end
                ISSUE_WRITE: begin
                    if (aw_hs) begin
                        aw_valid_o <= 1'b0;
                    end
                    if (w_hs) begin
                        w_valid_o <= 1'b0;
                    end
                    if (aw_done && w_done) begin
                        state_q <= ISSUE_IDLE;
                    end
                end
                ISSUE_READ: begin
                    if (ar_hs) begin
                        ar_valid_o <= 1'b0;
                        state_q    <= ISSUE_IDLE;
                    end
                end
                default: begin
                    state_q <= ISSUE_IDLE;
                end
            endcase
        end
    end

    // Response register: one-cycle OBI response pulse after each B/R handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            obi_rvalid_o <= 1'b0;
            obi_rdata_o  <= '0;
            obi_err_o    <= 1'b0;
        end else begin
            obi_rvalid_o <= b_hs | r_hs;
            obi_rdata_o  <= r_hs ? r_data_i : '0;
            obi_err_o    <= (r_hs & resp_is_error(r_resp_i)) |
                            (b_hs & resp_is_error(b_resp_i));
        end
    end

endmodule

// File: tb/tb_obi_to_axi_lite_bridge.sv
// Directed bench for obi_to_axi_lite_bridge with a transaction-level model.
module tb_obi_to_axi_lite_bridge;

    localparam int MAX_OUT = 2;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    logic        clk_i, rst_ni;
    logic        obi_req_i, obi_gnt_o, obi_we_i;
    logic [31:0] obi_addr_i, obi_wdata_i, obi_rdata_o;
    logic [3:0]  obi_be_i;
    logic        obi_rvalid_o, obi_err_o;
    logic [31:0] aw_addr_o, w_data_o, ar_addr_o, r_data_i;
    logic [2:0]  aw_prot_o, ar_prot_o;
    logic        aw_valid_o, aw_ready_i, w_valid_o, w_ready_i;
    logic [3:0]  w_strb_o;
    logic [1:0]  b_resp_i, r_resp_i;
    logic        b_valid_i, b_ready_o, ar_valid_o, ar_ready_i, r_valid_i, r_ready_o;
    logic        busy_o;
    logic [1:0]  outstanding_o;

    obi_to_axi_lite_bridge dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .obi_req_i     (obi_req_i),
        .obi_gnt_o     (obi_gnt_o),
        .obi_addr_i    (obi_addr_i),
        .obi_we_i      (obi_we_i),
        .obi_be_i      (obi_be_i),
        .obi_wdata_i   (obi_wdata_i),
        .obi_rvalid_o  (obi_rvalid_o),
        .obi_rdata_o   (obi_rdata_o),
        .obi_err_o     (obi_err_o),
        .aw_addr_o     (aw_addr_o),
        .aw_prot_o     (aw_prot_o),
        .aw_valid_o    (aw_valid_o),
        .aw_ready_i    (aw_ready_i),
        .w_data_o      (w_data_o),
        .w_strb_o      (w_strb_o),
        .w_valid_o     (w_valid_o),
        .w_ready_i     (w_ready_i),
        .b_resp_i      (b_resp_i),
        .b_valid_i     (b_valid_i),
        .b_ready_o     (b_ready_o),
        .ar_addr_o     (ar_addr_o),
        .ar_prot_o     (ar_prot_o),
        .ar_valid_o    (ar_valid_o),
        .ar_ready_i    (ar_ready_i),
        .r_data_i      (r_data_i),
        .r_resp_i      (r_resp_i),
        .r_valid_i     (r_valid_i),
        .r_ready_o     (r_ready_o),
        .busy_o        (busy_o),
        .outstanding_o (outstanding_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h t=%0t", name, act, exp, $time);
    endtask

    // ---------------- transaction-level model ----------------
    txn_t        txn_q[$];   // granted, response not yet handshaken
    txn_t        iss_q[$];   // granted, AXI request not yet fully accepted
    bit          aw_seen, w_seen;
    bit          rsp_pend;
    logic [31:0] rsp_data;
    logic        rsp_err;

    always @(negedge clk_i) begin : model
        int   n;
        txn_t cur;
        txn_t t;
        logic exp_b, exp_r, b_hs, r_hs;
        if (!rst_ni) begin
            txn_q.delete();
            iss_q.delete();
            aw_seen  = 0;
            w_seen   = 0;
            rsp_pend = 0;
            rsp_data = '0;
            rsp_err  = 0;
        end else begin
            n = txn_q.size();
            chk("outstanding", outstanding_o, n);
            chk("busy", busy_o, n != 0);
            chk("gnt", obi_gnt_o, obi_req_i && iss_q.size() == 0 && n < MAX_OUT);
            chk("rvalid", obi_rvalid_o, rsp_pend);
            if (rsp_pend) begin
                chk("rdata", obi_rdata_o, rsp_data);
                chk("err", obi_err_o, rsp_err);
            end
            exp_b = 0;
            exp_r = 0;
            if (n != 0 && !rsp_pend) begin
                exp_b = txn_q[0].we;
                exp_r = !txn_q[0].we;
            end
            chk("b_ready", b_ready_o, exp_b);
            chk("r_ready", r_ready_o, exp_r);
            if (iss_q.size() != 0) begin
                cur = iss_q[0];
                chk("aw_valid", aw_valid_o, cur.we && !aw_seen);
                chk("w_valid", w_valid_o, cur.we && !w_seen);
                chk("ar_valid", ar_valid_o, !cur.we);
                if (aw_valid_o) begin
                    chk("aw_addr", aw_addr_o, cur.addr);
                    chk("aw_prot", aw_prot_o, 3'b000);
                end
                if (w_valid_o) begin
                    chk("w_data", w_data_o, cur.wdata);
                    chk("w_strb", w_strb_o, cur.be);
                end
                if (ar_valid_o) begin
                    chk("ar_addr", ar_addr_o, cur.addr);
                    chk("ar_prot", ar_prot_o, 3'b000);
                end
            end else begin
                chk("aw_valid idle", aw_valid_o, 0);
                chk("w_valid idle", w_valid_o, 0);
                chk("ar_valid idle", ar_valid_o, 0);
            end

            // advance the model to what the coming clock edge does
            b_hs = b_valid_i && b_ready_o;
            r_hs = r_valid_i && r_ready_o;
            rsp_pend = 0;
            if ((b_hs || r_hs) && n != 0) begin
                rsp_pend = 1;
                rsp_data = r_hs ? r_data_i : 32'h0;
                rsp_err  = r_hs ? r_resp_i[1] : b_resp_i[1];
                void'(txn_q.pop_front());
            end
            if (iss_q.size() != 0) begin
                cur = iss_q[0];
                if (aw_valid_o && aw_ready_i) aw_seen = 1;
                if (w_valid_o && w_ready_i) w_seen = 1;
                if (cur.we ? (aw_seen && w_seen) : (ar_valid_o && ar_ready_i)) begin
                    void'(iss_q.pop_front());
                    aw_seen = 0;
                    w_seen  = 0;
                end
            end
            if (obi_req_i && obi_gnt_o) begin
                t = '{we: obi_we_i, addr: obi_addr_i, wdata: obi_wdata_i, be: obi_be_i};
                txn_q.push_back(t);
                iss_q.push_back(t);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic obi_issue(input logic we, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] be, output int gc);
        bit ok;
        ok = 0;
        gc = -1;
        obi_req_i = 1; obi_we_i = we; obi_addr_i = a; obi_wdata_i = d; obi_be_i = be;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (obi_gnt_o) begin ok = 1; gc = cyc; break; end
        end
        @(posedge clk_i);
        #1;
        obi_req_i = 0; obi_we_i = 0; obi_addr_i = '0; obi_wdata_i = '0; obi_be_i = '0;
        chk("obi grant", ok, 1);
    endtask

    task automatic send_b(input logic [1:0] resp);
        bit ok;
        ok = 0;
        b_valid_i = 1; b_resp_i = resp;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (b_ready_o) begin ok = 1; break; end
        end
        @(posedge clk_i);
        #1;
        b_valid_i = 0; b_resp_i = 2'b00;
        chk("b handshake", ok, 1);
    endtask

    task automatic send_r(input logic [31:0] d, input logic [1:0] resp);
        bit ok;
        ok = 0;
        r_valid_i = 1; r_data_i = d; r_resp_i = resp;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (r_ready_o) begin ok = 1; break; end
        end
        @(posedge clk_i);
        #1;
        r_valid_i = 0; r_data_i = '0; r_resp_i = 2'b00;
        chk("r handshake", ok, 1);
    endtask

    task automatic wait_rsp(input string name, input logic [31:0] d, input logic e, output int at);
        at = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (obi_rvalid_o) begin at = cyc; break; end
        end
        chk({name, " rsp seen"}, at >= 0, 1);
        chk({name, " rdata"}, obi_rdata_o, d);
        chk({name, " err"}, obi_err_o, e);
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    int  g, g2, at;
    bit  ok;

    initial begin
        rst_ni = 0;
        obi_req_i = 0; obi_we_i = 0; obi_addr_i = '0; obi_wdata_i = '0; obi_be_i = '0;
        aw_ready_i = 0; w_ready_i = 0; ar_ready_i = 0;
        b_valid_i = 0; b_resp_i = 2'b00;
        r_valid_i = 0; r_data_i = '0; r_resp_i = 2'b00;

        #3;
        chk("reset gnt", obi_gnt_o, 0);
        chk("reset rvalid", obi_rvalid_o, 0);
        chk("reset rdata", obi_rdata_o, 0);
        chk("reset err", obi_err_o, 0);
        chk("reset aw_valid", aw_valid_o, 0);
        chk("reset w_valid", w_valid_o, 0);
        chk("reset ar_valid", ar_valid_o, 0);
        chk("reset aw_addr", aw_addr_o, 0);
        chk("reset b_ready", b_ready_o, 0);
        chk("reset r_ready", r_ready_o, 0);
        chk("reset outstanding", outstanding_o, 0);
        chk("reset busy", busy_o, 0);
        repeat (3) @(posedge clk_i);
        #1;
        rst_ni = 1;
        tick();

        // T1: single write, slave ready at once, OKAY
        aw_ready_i = 1; w_ready_i = 1; ar_ready_i = 1;
        obi_issue(1, 32'h0000_1000, 32'hDEAD_BEEF, 4'hF, g);
        chk("t1 aw_addr", aw_addr_o, 32'h0000_1000);
        chk("t1 w_strb", w_strb_o, 4'hF);
        chk("t1 w_data", w_data_o, 32'hDEAD_BEEF);
        tick();
        send_b(2'b00);
        wait_rsp("t1", 32'h0, 1'b0, at);
        chk("t1 latency", at - g, 3);
        chk("t1 single pulse", obi_rvalid_o, 0);

        // T2: single read with SLVERR
        obi_issue(0, 32'h0000_2004, 32'h0, 4'h0, g);
        chk("t2 ar_valid", ar_valid_o, 1);
        chk("t2 ar_addr", ar_addr_o, 32'h0000_2004);
        tick();
        send_r(32'h1234_5678, 2'b10);
        wait_rsp("t2", 32'h1234_5678, 1'b1, at);
        chk("t2 latency", at - g, 3);
        chk("t2 single pulse", obi_rvalid_o, 0);

        // T3: W channel stalled three cycles after AW accepted
        w_ready_i = 0;
        obi_issue(1, 32'h0000_1100, 32'hA5A5_0F0F, 4'h3, g);
        chk("t3 aw_valid up", aw_valid_o, 1);
        chk("t3 w_valid up", w_valid_o, 1);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("t3 aw dropped", aw_valid_o, 0);
            chk("t3 w held", w_valid_o, 1);
            chk("t3 w data stable", w_data_o, 32'hA5A5_0F0F);
            chk("t3 w strb stable", w_strb_o, 4'h3);
            if (i == 2) w_ready_i = 1;
            tick();
        end
        chk("t3 w dropped", w_valid_o, 0);
        send_b(2'b00);
        wait_rsp("t3", 32'h0, 1'b0, at);
        repeat (2) begin
            chk("t3 no extra rsp", obi_rvalid_o, 0);
            tick();
        end

        // T4: FIFO full with three reads, R held back
        obi_issue(0, 32'h0000_3000, 32'h0, 4'h0, g);
        obi_issue(0, 32'h0000_3004, 32'h0, 4'h0, g2);
        chk("t4 b2b grant spacing", g2 - g, 2);
        obi_req_i = 1; obi_we_i = 0; obi_addr_i = 32'h0000_3008;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("t4 third gnt held", obi_gnt_o, 0);
            chk("t4 outstanding full", outstanding_o, 2);
        end
        tick();
        send_r(32'h0000_00A1, 2'b00);
        @(negedge clk_i);
        chk("t4 gnt after pop", obi_gnt_o, 1);
        @(posedge clk_i);
        #1;
        obi_req_i = 0; obi_addr_i = '0;
        send_r(32'h0000_00B2, 2'b00);
        send_r(32'h0000_00C3, 2'b01);
        repeat (3) tick();
        chk("t4 drained", outstanding_o, 0);

        // T5: R offered before B; writes respond first
        obi_issue(1, 32'h0000_4000, 32'h1111_2222, 4'hF, g);
        obi_issue(0, 32'h0000_4004, 32'h0, 4'h0, g);
        r_valid_i = 1; r_data_i = 32'hCAFE_F00D; r_resp_i = 2'b00;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("t5 r blocked", r_ready_o, 0);
        end
        tick();
        send_b(2'b11);
        chk("t5 first rsp", obi_rvalid_o, 1);
        chk("t5 first rdata", obi_rdata_o, 32'h0);
        chk("t5 first err", obi_err_o, 1);
        ok = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk_i);
            if (r_ready_o) begin ok = 1; break; end
        end
        @(posedge clk_i);
        #1;
        r_valid_i = 0; r_data_i = '0;
        chk("t5 r accepted", ok, 1);
        chk("t5 second rsp", obi_rvalid_o, 1);
        chk("t5 second rdata", obi_rdata_o, 32'hCAFE_F00D);
        chk("t5 second err", obi_err_o, 0);
        repeat (2) tick();

        // T6: asynchronous reset with two reads outstanding
        obi_issue(0, 32'h0000_5000, 32'h0, 4'h0, g);
        obi_issue(0, 32'h0000_5004, 32'h0, 4'h0, g);
        chk("t6 outstanding before", outstanding_o, 2);
        #2;
        rst_ni = 0;
        #1;
        chk("t6 outstanding", outstanding_o, 0);
        chk("t6 busy", busy_o, 0);
        chk("t6 ar_valid", ar_valid_o, 0);
        chk("t6 ar_addr", ar_addr_o, 0);
        chk("t6 r_ready", r_ready_o, 0);
        chk("t6 rvalid", obi_rvalid_o, 0);
        @(posedge clk_i);
        #1;
        rst_ni = 1;
        tick();
        obi_issue(0, 32'h0000_6008, 32'h0, 4'h0, g);
        tick();
        send_r(32'h0BAD_F00D, 2'b00);
        wait_rsp("t6", 32'h0BAD_F00D, 1'b0, at);
        chk("t6 latency", at - g, 3);
        repeat (2) tick();
        chk("end outstanding", outstanding_o, 0);
        chk("end busy", busy_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
